// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential divider.
//                - div_state_e   : FSM state encoding (IDLE, RUN, DONE)
//                - div_cnt_width : iteration-counter width, $clog2(size+1)
//                - DIV_DBZ_QUO   : all-ones divide-by-zero quotient, sliced
//                                  down to the divider width by the user
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Widest divider the all-ones constant can serve.
    localparam int unsigned DIV_MAX_SIZE = 64;

    // RISC-V divide-by-zero quotient (all ones at any width up to DIV_MAX_SIZE).
    localparam logic [DIV_MAX_SIZE-1:0] DIV_DBZ_QUO = {DIV_MAX_SIZE{1'b1}};

    // Counter must hold the value SIZE itself, hence SIZE+1.
    function automatic int unsigned div_cnt_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    localparam int unsigned DIV_CNT_W_DEFAULT = div_cnt_width(32);

endpackage
`default_nettype wire

// File: rtl/ripple_carry_adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_carry_adder_subtractor
//  Description : WIDTH-bit ripple-carry adder/subtractor.
//                CTRL=0 : sum_o = a_i + b_i
//                CTRL=1 : sum_o = a_i - b_i  (a_i + ~b_i + 1)
//                In subtract mode cout_o=1 means no borrow (a_i >= b_i).
//  Ports       : a_i, b_i  operands
//                sum_o     sum / difference
//                cout_o    carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter bit          CTRL  = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] b_eff;
    logic             carry;

    assign b_eff = CTRL ? ~b_i : b_i;

    // Carry rippled through a loop variable so the chain is one combinational
    // process rather than a vector feeding back on itself.
    always_comb begin
        carry = CTRL;
        sum_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum_o[i] = a_i[i] ^ b_eff[i] ^ carry;
            carry    = (a_i[i] & b_eff[i]) | (carry & (a_i[i] ^ b_eff[i]));
        end
        cout_o = carry;
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//                One quotient bit per clock; SIZE+1 cycles from start to
//                valid, 1 cycle for divide-by-zero.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                start           request strobe (sampled in IDLE only)
//                is_signed       1 = two's-complement operation
//                dividend,divisor operands, sampled with start
//                busy            high in RUN and DONE
//                valid           one-cycle result strobe
//                quotient,remainder,div_by_zero  registered results
//  Config      : `DIV_SIGNED_EN  - when defined, is_signed is honoured and the
//                                  sign conversion logic is built; otherwise
//                                  every operation is unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            valid,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);

    localparam int unsigned     CNT_W      = div_cnt_width(SIZE);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(1);
    localparam logic [SIZE-1:0]  C_DBZ_QUO  = DIV_DBZ_QUO[SIZE-1:0];

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SIZE-1:0]   rem_q;
    logic [SIZE-1:0]   quo_q;
    logic [SIZE-1:0]   dvsr_q;
    logic [SIZE-1:0]   quotient_q;
    logic [SIZE-1:0]   remainder_q;
    logic              dbz_q;
    logic              valid_q;
    logic              busy_q;

    logic [SIZE-1:0]   dvnd_mag;
    logic [SIZE-1:0]   dvsr_mag;
    logic [SIZE-1:0]   rem_d;
    logic [SIZE-1:0]   quo_d;
    logic [SIZE-1:0]   quotient_d;
    logic [SIZE-1:0]   remainder_d;

    // ------------------------------------------------------------------
    // Operand capture: magnitudes and result signs
    // ------------------------------------------------------------------
`ifdef DIV_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;
    logic neg_quo_d;
    logic neg_rem_d;
    logic dvsr_neg;

    assign neg_rem_d = is_signed & dividend[SIZE-1];
    assign dvsr_neg  = is_signed & divisor[SIZE-1];
    assign neg_quo_d = neg_rem_d ^ dvsr_neg;
    // -2^(SIZE-1) negates to itself, which is already its unsigned magnitude.
    assign dvnd_mag  = neg_rem_d ? -dividend : dividend;
    assign dvsr_mag  = dvsr_neg  ? -divisor  : divisor;
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign dvnd_mag           = dividend;
    assign dvsr_mag           = divisor;
`endif

    // ------------------------------------------------------------------
    // One restoring step: shift {rem,quo} left, trial-subtract divisor
    // ------------------------------------------------------------------
    logic [SIZE:0] trial_a;
    logic [SIZE:0] trial_b;
    logic [SIZE:0] trial_diff;
    logic          trial_cout;
    logic          borrow;
    logic          w_unused_diff_msb;

    assign trial_a = {rem_q, quo_q[SIZE-1]};
    assign trial_b = {1'b0, dvsr_q};

    ripple_carry_adder_subtractor #(
        .WIDTH (SIZE + 1),
        .CTRL  (1'b1)
    ) u_trial_sub (
        .a_i    (trial_a),
        .b_i    (trial_b),
        .sum_o  (trial_diff),
        .cout_o (trial_cout)
    );

    assign borrow = ~trial_cout;
    // Partial remainder is always below the divisor, so the top bit of the
    // difference is zero whenever it is kept.
    assign w_unused_diff_msb = trial_diff[SIZE];
    assign rem_d = borrow ? trial_a[SIZE-1:0] : trial_diff[SIZE-1:0];
    assign quo_d = {quo_q[SIZE-2:0], ~borrow};

    // Final results are taken from the last step's next values so they are
    // registered on the same edge that enters DONE.
`ifdef DIV_SIGNED_EN
    assign quotient_d  = neg_quo_q ? -quo_d : quo_d;
    assign remainder_d = neg_rem_q ? -rem_d : rem_d;
`else
    assign quotient_d  = quo_d;
    assign remainder_d = rem_d;
`endif

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            state_q     <= ST_DONE;
                            quotient_q  <= C_DBZ_QUO;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            cnt_q   <= C_CNT_LOAD;
                            rem_q   <= '0;
                            quo_q   <= dvnd_mag;
                            dvsr_q  <= dvsr_mag;
`ifdef DIV_SIGNED_EN
                            neg_quo_q <= neg_quo_d;
                            neg_rem_q <= neg_rem_d;
`endif
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - C_CNT_LAST;
                    if (cnt_q == C_CNT_LAST) begin
                        state_q     <= ST_DONE;
                        quotient_q  <= quotient_d;
                        remainder_q <= remainder_d;
                        dbz_q       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign valid       = valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
